// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 scan-code bytes to one-cycle key events
// ASCII lookup is built only when PS2_DECODER_ASCII_EN is defined.
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       ascii,
  output logic             shift_held,
  output logic             caps_lock,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    ST_BASE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             ack_q, ack_d;
  logic             held_q, held_d;
  logic             held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic             rep_q, rep_d;

  logic             accept;
  logic             emit;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_rel;
  logic             ev_match;
  logic             ev_rep;

  assign accept = kbd_ready && !ack_q;

  // Prefix/pause FSM: decides whether the accepted byte completes an event.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ack_d   = 1'b0;
    emit    = 1'b0;
    ev_code = kbd_data;
    ev_ext  = 1'b0;
    ev_rel  = 1'b0;
    if (accept) begin
      ack_d = 1'b1;
      if (state_q == ST_PAUSE) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          emit    = 1'b1;
          ev_code = 8'hE1;
          state_d = ST_BASE;
        end
      end else if (kbd_data == 8'hE0) begin
        state_d = (state_q == ST_E0F0) ? ST_E0F0 : ST_E0;
      end else if (kbd_data == 8'hF0) begin
        state_d = (state_q == ST_E0 || state_q == ST_E0F0) ? ST_E0F0 : ST_F0;
      end else if (kbd_data == 8'hE1 && state_q == ST_BASE) begin
        state_d = ST_PAUSE;
        skip_d  = 3'd7;
      end else begin
        emit    = 1'b1;
        ev_ext  = (state_q == ST_E0) || (state_q == ST_E0F0);
        ev_rel  = (state_q == ST_F0) || (state_q == ST_E0F0);
        state_d = ST_BASE;
      end
    end
  end

  assign ev_match = held_q && (held_ext_q == ev_ext) && (held_code_q == ev_code);
  assign ev_rep   = !ev_rel && ev_match;

  always_comb begin
    held_d      = held_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    rep_d       = rep_q;
    if (emit) begin
      code_d = ev_code;
      ext_d  = ev_ext;
      rel_d  = ev_rel;
      rep_d  = ev_rep;
      if (!ev_rel) begin
        if (!ev_match) begin
          held_d      = 1'b1;
          held_ext_d  = ev_ext;
          held_code_d = ev_code;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end else if (ev_match) begin
        held_d = 1'b0;
      end
      if (!ev_ext && ev_code == 8'h12) lshift_d = !ev_rel;
      if (!ev_ext && ev_code == 8'h59) rshift_d = !ev_rel;
      if (!ev_ext && ev_code == 8'h58 && !ev_rel && !ev_match) caps_d = !caps_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_BASE;
      skip_q      <= 3'd0;
      ack_q       <= 1'b0;
      held_q      <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      ack_q       <= ack_d;
      held_q      <= held_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      cnt_q       <= cnt_d;
      valid_q     <= emit;
      code_q      <= code_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      rep_q       <= rep_d;
    end
  end

`ifdef PS2_DECODER_ASCII_EN
  logic [7:0] ascii_q, ascii_d;

  // Lookup sees modifier state from before this event is applied.
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh, input logic cp);
    logic [7:0] lower;
    logic [7:0] res;
    lower = 8'h00;
    res   = 8'h00;
    case (c)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";  8'h23: lower = "d";
      8'h24: lower = "e";  8'h2B: lower = "f";  8'h34: lower = "g";  8'h33: lower = "h";
      8'h43: lower = "i";  8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";  8'h4D: lower = "p";
      8'h15: lower = "q";  8'h2D: lower = "r";  8'h1B: lower = "s";  8'h2C: lower = "t";
      8'h3C: lower = "u";  8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      default: lower = 8'h00;
    endcase
    if (lower != 8'h00) begin
      res = (sh ^ cp) ? (lower - 8'h20) : lower;
    end else begin
      case (c)
        8'h16: res = sh ? "!" : "1";
        8'h1E: res = sh ? "@" : "2";
        8'h26: res = sh ? "#" : "3";
        8'h25: res = sh ? "$" : "4";
        8'h2E: res = sh ? "%" : "5";
        8'h36: res = sh ? "^" : "6";
        8'h3D: res = sh ? "&" : "7";
        8'h3E: res = sh ? "*" : "8";
        8'h46: res = sh ? "(" : "9";
        8'h45: res = sh ? ")" : "0";
        8'h29: res = 8'h20;
        8'h5A: res = 8'h0D;
        8'h66: res = 8'h08;
        8'h76: res = 8'h1B;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  always_comb begin
    ascii_d = ascii_q;
    if (emit) begin
      ascii_d = (ev_ext || state_q == ST_PAUSE) ? 8'h00
              : to_ascii(ev_code, lshift_q | rshift_q, caps_q);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) ascii_q <= 8'h00;
    else       ascii_q <= ascii_d;
  end

  assign ascii = ascii_q;
`else
  assign ascii = 8'h00;
`endif

  assign kbd_nextdata_n = ~ack_q;
  assign key_valid      = valid_q;
  assign key_code       = code_q;
  assign key_ext        = ext_q;
  assign key_release    = rel_q;
  assign key_repeat     = rep_q;
  assign shift_held     = lshift_q | rshift_q;
  assign caps_lock      = caps_q;
  assign press_count    = cnt_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - scoreboard bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic             key_repeat;
  logic [7:0]       ascii;
  logic             shift_held;
  logic             caps_lock;
  logic [CNT_W-1:0] press_count;

  ps2_scancode_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .key_repeat(key_repeat),
    .ascii(ascii), .shift_held(shift_held), .caps_lock(caps_lock),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] asc;
    logic       shift;
    logic       caps;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                           input logic rep, input logic [7:0] asc, input logic sh,
                           input logic cp, input logic [7:0] cnt);
    ev_t e;
    e.code = code; e.ext = ext; e.rel = rel; e.rep = rep;
`ifdef PS2_DECODER_ASCII_EN
    e.asc = asc;
`else
    e.asc = 8'h00;
`endif
    e.shift = sh; e.caps = cp; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || !kbd_nextdata_n) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  // Receiver FIFO model: head byte presented, popped after a low nextdata_n cycle.
  initial begin
    logic pop_n;
    kbd_data  = 8'h00;
    kbd_ready = 1'b0;
    forever begin
      @(negedge clk);
      pop_n = kbd_nextdata_n;
      @(posedge clk);
      #1;
      if (!pop_n && fifo.size() > 0) void'(fifo.pop_front());
      kbd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      kbd_ready = (fifo.size() > 0);
    end
  end

  // Monitor: compares each key_valid pulse against the scoreboard head.
  always @(negedge clk) begin
    if (clrn && key_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {24'h0, key_code}, 32'hFFFF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("code",    key_code,    e.code);
        chk("ext",     key_ext,     e.ext);
        chk("release", key_release, e.rel);
        chk("repeat",  key_repeat,  e.rep);
        chk("ascii",   ascii,       e.asc);
        chk("shift",   shift_held,  e.shift);
        chk("caps",    caps_lock,   e.caps);
        chk("count",   press_count, e.cnt);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nextdata_n"}, kbd_nextdata_n, 1);
    chk({tag, "_valid"},      key_valid,      0);
    chk({tag, "_code"},       key_code,       0);
    chk({tag, "_flags"},      {key_ext, key_release, key_repeat}, 0);
    chk({tag, "_ascii"},      ascii,          0);
    chk({tag, "_mods"},       {shift_held, caps_lock}, 0);
    chk({tag, "_count"},      press_count,    0);
  endtask

  initial begin
    int lows, dbl;
    logic prev;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    clrn = 1'b1;

    // make/break of 'a'
    expect_ev(8'h1C, 0, 0, 0, 8'h61, 0, 0, 8'd1);
    expect_ev(8'h1C, 0, 1, 0, 8'h61, 0, 0, 8'd1);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();

    // left shift + a
    expect_ev(8'h12, 0, 0, 0, 8'h00, 1, 0, 8'd2);
    expect_ev(8'h1C, 0, 0, 0, 8'h41, 1, 0, 8'd3);
    expect_ev(8'h1C, 0, 1, 0, 8'h41, 1, 0, 8'd3);
    expect_ev(8'h12, 0, 1, 0, 8'h00, 0, 0, 8'd3);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    drain();

    // extended make/break
    expect_ev(8'h75, 1, 0, 0, 8'h00, 0, 0, 8'd4);
    expect_ev(8'h75, 1, 1, 0, 8'h00, 0, 0, 8'd4);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // typematic repeat
    expect_ev(8'h1C, 0, 0, 0, 8'h61, 0, 0, 8'd5);
    expect_ev(8'h1C, 0, 0, 1, 8'h61, 0, 0, 8'd5);
    expect_ev(8'h1C, 0, 0, 1, 8'h61, 0, 0, 8'd5);
    expect_ev(8'h1C, 0, 1, 0, 8'h61, 0, 0, 8'd5);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();

    // Pause sequence, then '1' proves return to BASE
    expect_ev(8'hE1, 0, 0, 0, 8'h00, 0, 0, 8'd6);
    expect_ev(8'h16, 0, 0, 0, 8'h31, 0, 0, 8'd7);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h16);
    drain();

    // Caps Lock and Shift interplay
    expect_ev(8'h58, 0, 0, 0, 8'h00, 0, 1, 8'd8);
    expect_ev(8'h1C, 0, 0, 0, 8'h41, 0, 1, 8'd9);
    expect_ev(8'h1C, 0, 1, 0, 8'h41, 0, 1, 8'd9);
    expect_ev(8'h58, 0, 1, 0, 8'h00, 0, 1, 8'd9);
    expect_ev(8'h12, 0, 0, 0, 8'h00, 1, 1, 8'd10);
    expect_ev(8'h16, 0, 0, 0, 8'h21, 1, 1, 8'd11);
    expect_ev(8'h1C, 0, 0, 0, 8'h61, 1, 1, 8'd12);
    expect_ev(8'h1C, 0, 1, 0, 8'h61, 1, 1, 8'd12);
    expect_ev(8'h12, 0, 1, 0, 8'h00, 0, 1, 8'd12);
    expect_ev(8'h59, 0, 0, 0, 8'h00, 1, 1, 8'd13);
    expect_ev(8'h59, 0, 1, 0, 8'h00, 0, 1, 8'd13);
    send(8'h58); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h58);
    send(8'h12); send(8'h16); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h59); send(8'hF0); send(8'h59);
    drain();

    // back-to-back throughput: pop pulse every other cycle
    expect_ev(8'h29, 0, 0, 0, 8'h20, 0, 1, 8'd14);
    expect_ev(8'h5A, 0, 0, 0, 8'h0D, 0, 1, 8'd15);
    expect_ev(8'h66, 0, 0, 0, 8'h08, 0, 1, 8'd16);
    expect_ev(8'h76, 0, 0, 0, 8'h1B, 0, 1, 8'd17);
    send(8'h29); send(8'h5A); send(8'h66); send(8'h76);
    lows = 0; dbl = 0; prev = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!kbd_nextdata_n) lows++;
      if (!kbd_nextdata_n && !prev) dbl++;
      prev = kbd_nextdata_n;
    end
    chk("pop_pulses", lows, 4);
    chk("pop_back_to_back", dbl, 0);
    drain();

    // reset between prefix and code discards the prefix
    send(8'hE0);
    drain();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    clrn = 1'b1;
    expect_ev(8'h75, 0, 0, 0, 8'h00, 0, 0, 8'd1);
    send(8'h75);
    drain();

    chk("events_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
